// File: rtl/filter_core_pkg.sv
// Types and timing defaults shared by the FPGA-Pico REQ/ACK link transmitter and receiver.
package filter_core_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      WAIT_ACK_HI,
      WAIT_ACK_LO
   } tx_state_t;

   localparam int CLK_FREQ           = 50_000_000;
   localparam int DEFAULT_TX_TIMEOUT = CLK_FREQ;

   // Bits needed to hold 0..max_val; never less than one bit.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level (ack here, req on the receive side).
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/status_tx_handshake.sv
// FPGA-to-Pico status word transmitter: 4-phase REQ/ACK with a one-deep pending word,
// per-edge ack timeout and optional heartbeat resend of the last word.
module status_tx_handshake
   import filter_core_pkg::*;
#(
   parameter int DATA_WIDTH     = 4,
   parameter int SYNC_STAGES    = 2,
   parameter int SETUP_CYCLES   = 2,
   parameter int TIMEOUT_CYCLES = DEFAULT_TX_TIMEOUT,
   parameter int REFRESH_CYCLES = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] send_data,
   input  logic                  send_valid,
   input  logic                  ack,
   output logic                  req,
   output logic [DATA_WIDTH-1:0] tx_data,
   output logic                  busy,
   output logic                  done_pulse,
   output logic                  timeout_pulse,
   output logic                  drop_pulse
);

   localparam int CNT_MAX = (SETUP_CYCLES > TIMEOUT_CYCLES) ? SETUP_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = cnt_width(CNT_MAX);
   localparam int REF_W   = cnt_width(REFRESH_CYCLES);

   localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYCLES);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(CNT_MAX);
   localparam logic [REF_W-1:0] REF_LAST     = REF_W'((REFRESH_CYCLES > 0) ? REFRESH_CYCLES - 1 : 0);
   localparam logic [REF_W-1:0] REF_SAT      = REF_W'(REFRESH_CYCLES);

   tx_state_t             state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
   logic [REF_W-1:0]      refresh_cnt_q, refresh_cnt_d;
   logic                  req_q, req_d;
   logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
   logic [DATA_WIDTH-1:0] last_word_q, last_word_d;
   logic                  pend_valid_q, pend_valid_d;
   logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;
   logic                  timed_out_q, timed_out_d;
   logic                  done_q, done_d;
   logic                  timeout_q, timeout_d;
   logic                  drop_q, drop_d;
   logic                  launch;
   logic                  send_taken;
   logic [DATA_WIDTH-1:0] launch_word;
   logic                  ack_s;

   sync_ff #(
      .STAGES (SYNC_STAGES)
   ) u_ack_sync (
      .clk   (clk),
      .reset (reset),
      .d     (ack),
      .q     (ack_s)
   );

   assign cnt_inc = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      refresh_cnt_d = '0;
      req_d         = req_q;
      tx_data_d     = tx_data_q;
      last_word_d   = last_word_q;
      pend_valid_d  = pend_valid_q;
      pend_data_d   = pend_data_q;
      timed_out_d   = timed_out_q;
      done_d        = 1'b0;
      timeout_d     = 1'b0;
      drop_d        = 1'b0;
      launch        = 1'b0;
      send_taken    = 1'b0;
      launch_word   = '0;

      case (state_q)
         IDLE: begin
            // A stale ack from the previous exchange blocks any launch until it clears.
            if (!ack_s) begin
               if (pend_valid_q) begin
                  launch       = 1'b1;
                  launch_word  = pend_data_q;
                  pend_valid_d = 1'b0;
               end else if (send_valid) begin
                  launch      = 1'b1;
                  launch_word = send_data;
                  send_taken  = 1'b1;
               end else if (REFRESH_CYCLES > 0 && refresh_cnt_q >= REF_LAST) begin
                  launch      = 1'b1;
                  launch_word = last_word_q;
               end
            end
            if (REFRESH_CYCLES > 0 && !launch && !pend_valid_q && !send_valid) begin
               refresh_cnt_d = (refresh_cnt_q == REF_SAT) ? refresh_cnt_q : refresh_cnt_q + REF_W'(1);
            end
         end
         SETUP: begin
            if (cnt_q == SETUP_LAST) begin
               req_d   = 1'b1;
               cnt_d   = '0;
               state_d = WAIT_ACK_HI;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         WAIT_ACK_HI: begin
            // Timeout is tested first so it wins over an ack arriving on the same edge.
            if (cnt_q == TIMEOUT_LAST) begin
               req_d       = 1'b0;
               timeout_d   = 1'b1;
               timed_out_d = 1'b1;
               cnt_d       = '0;
               state_d     = WAIT_ACK_LO;
            end else if (ack_s) begin
               req_d   = 1'b0;
               cnt_d   = '0;
               state_d = WAIT_ACK_LO;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         WAIT_ACK_LO: begin
            if (cnt_q == TIMEOUT_LAST) begin
               timeout_d = 1'b1;
               cnt_d     = '0;
               state_d   = IDLE;
            end else if (!ack_s) begin
               done_d  = !timed_out_q;
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: begin
            state_d = IDLE;
            req_d   = 1'b0;
            cnt_d   = '0;
         end
      endcase

      if (launch) begin
         tx_data_d   = launch_word;
         last_word_d = launch_word;
         timed_out_d = 1'b0;
         cnt_d       = '0;
         state_d     = SETUP;
      end

      // Anything not launched directly lands in pending; latest word wins.
      if (send_valid && !send_taken) begin
         drop_d       = pend_valid_d;
         pend_valid_d = 1'b1;
         pend_data_d  = send_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         refresh_cnt_q <= '0;
         req_q         <= 1'b0;
         tx_data_q     <= '0;
         last_word_q   <= '0;
         pend_valid_q  <= 1'b0;
         pend_data_q   <= '0;
         timed_out_q   <= 1'b0;
         done_q        <= 1'b0;
         timeout_q     <= 1'b0;
         drop_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         refresh_cnt_q <= refresh_cnt_d;
         req_q         <= req_d;
         tx_data_q     <= tx_data_d;
         last_word_q   <= last_word_d;
         pend_valid_q  <= pend_valid_d;
         pend_data_q   <= pend_data_d;
         timed_out_q   <= timed_out_d;
         done_q        <= done_d;
         timeout_q     <= timeout_d;
         drop_q        <= drop_d;
      end
   end

   assign req           = req_q;
   assign tx_data       = tx_data_q;
   assign busy          = (state_q != IDLE) || pend_valid_q;
   assign done_pulse    = done_q;
   assign timeout_pulse = timeout_q;
   assign drop_pulse    = drop_q;

endmodule

// File: tb/tb_status_tx_handshake.sv
// Directed bench for status_tx_handshake: one DUT without refresh, one with a 200-clock heartbeat.
module tb_status_tx_handshake;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   logic [3:0] send_data_a = '0;
   logic       send_valid_a = 1'b0;
   logic       man_ack_a = 1'b0;
   logic       pico_en_a = 1'b0;
   logic       pico_ack_a;
   logic       ack_a;
   logic       req_a, busy_a, done_a, tmo_a, drop_a;
   logic [3:0] tx_data_a;

   logic [3:0] send_data_r = '0;
   logic       send_valid_r = 1'b0;
   logic       pico_ack_r;
   logic       req_r, busy_r, done_r, tmo_r, drop_r;
   logic [3:0] tx_data_r;

   assign ack_a = pico_en_a ? pico_ack_a : man_ack_a;

   status_tx_handshake #(
      .DATA_WIDTH(4), .SYNC_STAGES(2), .SETUP_CYCLES(2), .TIMEOUT_CYCLES(100), .REFRESH_CYCLES(0)
   ) dut_a (
      .clk(clk), .reset(reset), .send_data(send_data_a), .send_valid(send_valid_a), .ack(ack_a),
      .req(req_a), .tx_data(tx_data_a), .busy(busy_a), .done_pulse(done_a),
      .timeout_pulse(tmo_a), .drop_pulse(drop_a)
   );

   status_tx_handshake #(
      .DATA_WIDTH(4), .SYNC_STAGES(2), .SETUP_CYCLES(2), .TIMEOUT_CYCLES(100), .REFRESH_CYCLES(200)
   ) dut_r (
      .clk(clk), .reset(reset), .send_data(send_data_r), .send_valid(send_valid_r), .ack(pico_ack_r),
      .req(req_r), .tx_data(tx_data_r), .busy(busy_r), .done_pulse(done_r),
      .timeout_pulse(tmo_r), .drop_pulse(drop_r)
   );

   // Pico model: ack rises on the 5th falling edge that sees req high, drops on the 3rd that sees req low.
   initial begin : pico_model_a
      int pc;
      pc = 0;
      pico_ack_a = 1'b0;
      forever begin
         @(negedge clk);
         if (!pico_en_a || reset) begin
            pico_ack_a = 1'b0;
            pc = 0;
         end else if (!pico_ack_a) begin
            if (req_a) begin
               pc++;
               if (pc == 5) begin pico_ack_a = 1'b1; pc = 0; end
            end else pc = 0;
         end else begin
            if (!req_a) begin
               pc++;
               if (pc == 3) begin pico_ack_a = 1'b0; pc = 0; end
            end else pc = 0;
         end
      end
   end

   initial begin : pico_model_r
      int pc;
      pc = 0;
      pico_ack_r = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            pico_ack_r = 1'b0;
            pc = 0;
         end else if (!pico_ack_r) begin
            if (req_r) begin
               pc++;
               if (pc == 5) begin pico_ack_r = 1'b1; pc = 0; end
            end else pc = 0;
         end else begin
            if (!req_r) begin
               pc++;
               if (pc == 3) begin pico_ack_r = 1'b0; pc = 0; end
            end else pc = 0;
         end
      end
   end

   initial begin : watchdog
      #500_000;
      $display("FAIL watchdog: time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      send_valid_a = 1'b0;
      send_valid_r = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      #2 reset = 1'b1;
      #1;
      tests++;
      if ({req_a, tx_data_a, busy_a, done_a, tmo_a, drop_a} !== 9'b0) begin
         fails++;
         $display("FAIL reset_outputs_a: got %b required 000000000", {req_a, tx_data_a, busy_a, done_a, tmo_a, drop_a});
      end
      tests++;
      if ({req_r, tx_data_r, busy_r} !== 6'b0) begin
         fails++;
         $display("FAIL reset_outputs_r: got %b required 000000", {req_r, tx_data_r, busy_r});
      end
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      repeat (5) tick();
      tests++;
      if (req_a !== 1'b0 || busy_a !== 1'b0) begin
         fails++;
         $display("FAIL reset_idle: req=%b busy=%b required 0 0", req_a, busy_a);
      end
   endtask

   task automatic test_single_send();
      pico_en_a = 1'b0;
      man_ack_a = 1'b0;
      send_data_a = 4'hA;
      send_valid_a = 1'b1;
      tick();
      send_valid_a = 1'b0;
      tests++;
      if (tx_data_a !== 4'hA || busy_a !== 1'b1 || req_a !== 1'b0) begin
         fails++;
         $display("FAIL single_accept: tx=%h busy=%b req=%b required A 1 0", tx_data_a, busy_a, req_a);
      end
      repeat (2) tick();
      tests++;
      if (req_a !== 1'b0) begin fails++; $display("FAIL single_req_early: req=%b required 0", req_a); end
      tick();
      tests++;
      if (req_a !== 1'b1) begin fails++; $display("FAIL single_req_rise: req=%b required 1", req_a); end
      repeat (4) tick();
      man_ack_a = 1'b1;
      repeat (2) tick();
      tests++;
      if (req_a !== 1'b1) begin fails++; $display("FAIL single_req_hold: req=%b required 1", req_a); end
      tick();
      tests++;
      if (req_a !== 1'b0 || tx_data_a !== 4'hA) begin
         fails++;
         $display("FAIL single_req_fall: req=%b tx=%h required 0 A", req_a, tx_data_a);
      end
      repeat (3) tick();
      man_ack_a = 1'b0;
      repeat (2) tick();
      tests++;
      if (done_a !== 1'b0) begin fails++; $display("FAIL single_done_early: done=%b required 0", done_a); end
      tick();
      tests++;
      if (done_a !== 1'b1) begin fails++; $display("FAIL single_done: done=%b required 1", done_a); end
      tick();
      tests++;
      if (done_a !== 1'b0 || busy_a !== 1'b0) begin
         fails++;
         $display("FAIL single_after: done=%b busy=%b required 0 0", done_a, busy_a);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] vals [3];
      logic [3:0] seq [$];
      logic       req_prev;
      logic [3:0] tx_prev;
      int         drops, dones, unstable;
      vals = '{4'h3, 4'h5, 4'h9};
      req_prev = 1'b0; tx_prev = '0; drops = 0; dones = 0; unstable = 0;
      pico_en_a = 1'b1;
      for (int cyc = 0; cyc < 300; cyc++) begin
         if (cyc < 3) begin
            send_valid_a = 1'b1;
            send_data_a = vals[cyc];
         end else send_valid_a = 1'b0;
         tick();
         if (req_a && !req_prev) seq.push_back(tx_data_a);
         if (req_a && req_prev && tx_data_a !== tx_prev) unstable++;
         if (drop_a) drops++;
         if (done_a) dones++;
         req_prev = req_a;
         tx_prev = tx_data_a;
         if (cyc >= 3 && dones == 2 && !busy_a) break;
      end
      send_valid_a = 1'b0;
      pico_en_a = 1'b0;
      tests++;
      if (seq.size() != 2) begin fails++; $display("FAIL b2b_count: sent %0d words required 2", seq.size()); end
      tests++;
      if (seq.size() < 1 || seq[0] !== 4'h3) begin fails++; $display("FAIL b2b_first: first word wrong or missing, required 3"); end
      tests++;
      if (seq.size() < 2 || seq[1] !== 4'h9) begin fails++; $display("FAIL b2b_second: second word wrong or missing, required 9"); end
      tests++;
      if (drops != 1) begin fails++; $display("FAIL b2b_drops: got %0d required 1", drops); end
      tests++;
      if (dones != 2) begin fails++; $display("FAIL b2b_dones: got %0d required 2", dones); end
      tests++;
      if (unstable != 0) begin fails++; $display("FAIL b2b_stable: tx changed %0d times under req, required 0", unstable); end
      tests++;
      if (busy_a !== 1'b0) begin fails++; $display("FAIL b2b_idle: busy=%b required 0", busy_a); end
   endtask

   task automatic test_timeout();
      int n, early, tmo_cnt, done_cnt;
      n = 0; early = 0; tmo_cnt = 0; done_cnt = 0;
      pico_en_a = 1'b0;
      man_ack_a = 1'b0;
      send_data_a = 4'h7;
      send_valid_a = 1'b1;
      tick();
      send_valid_a = 1'b0;
      while (!req_a && n < 10) begin tick(); n++; end
      tests++;
      if (n != 3 || req_a !== 1'b1) begin fails++; $display("FAIL tmo_req_rise: latency %0d req=%b required 3 1", n, req_a); end
      for (int i = 1; i <= 100; i++) begin
         tick();
         if (tmo_a) tmo_cnt++;
         if (done_a) done_cnt++;
         if (i < 100 && req_a !== 1'b1) early++;
      end
      tests++;
      if (req_a !== 1'b0 || tmo_a !== 1'b1) begin
         fails++;
         $display("FAIL tmo_abort: req=%b timeout=%b required 0 1", req_a, tmo_a);
      end
      tests++;
      if (early != 0) begin fails++; $display("FAIL tmo_early_drop: req low %0d clocks early, required 0", early); end
      repeat (2) begin
         tick();
         if (tmo_a) tmo_cnt++;
         if (done_a) done_cnt++;
      end
      tests++;
      if (tmo_cnt != 1) begin fails++; $display("FAIL tmo_pulses: got %0d required 1", tmo_cnt); end
      tests++;
      if (done_cnt != 0) begin fails++; $display("FAIL tmo_no_done: got %0d done pulses required 0", done_cnt); end
      tests++;
      if (busy_a !== 1'b0 || tx_data_a !== 4'h7) begin
         fails++;
         $display("FAIL tmo_idle: busy=%b tx=%h required 0 7", busy_a, tx_data_a);
      end
   endtask

   task automatic test_stale_ack();
      int rises, n;
      logic seen_done;
      rises = 0; n = 0; seen_done = 1'b0;
      pico_en_a = 1'b0;
      man_ack_a = 1'b1;
      do_reset();
      repeat (4) tick();
      send_data_a = 4'h2;
      send_valid_a = 1'b1;
      tick();
      send_valid_a = 1'b0;
      repeat (20) begin
         tick();
         if (req_a) rises++;
      end
      tests++;
      if (rises != 0 || busy_a !== 1'b1 || tx_data_a !== 4'h0) begin
         fails++;
         $display("FAIL stale_hold: req-high clocks %0d busy=%b tx=%h required 0 1 0", rises, busy_a, tx_data_a);
      end
      man_ack_a = 1'b0;
      repeat (2) tick();
      tests++;
      if (tx_data_a !== 4'h0) begin fails++; $display("FAIL stale_early_launch: tx=%h required 0", tx_data_a); end
      tick();
      tests++;
      if (tx_data_a !== 4'h2 || req_a !== 1'b0) begin
         fails++;
         $display("FAIL stale_launch: tx=%h req=%b required 2 0", tx_data_a, req_a);
      end
      pico_en_a = 1'b1;
      while (n < 100 && !seen_done) begin
         tick();
         n++;
         if (done_a) seen_done = 1'b1;
      end
      tests++;
      if (!seen_done) begin fails++; $display("FAIL stale_complete: done seen=%b required 1", seen_done); end
      tick();
      tests++;
      if (busy_a !== 1'b0) begin fails++; $display("FAIL stale_idle: busy=%b required 0", busy_a); end
      pico_en_a = 1'b0;
   endtask

   task automatic test_reset_mid_transfer();
      int n, rises, busy_seen;
      n = 0; rises = 0; busy_seen = 0;
      pico_en_a = 1'b1;
      send_data_a = 4'h6;
      send_valid_a = 1'b1;
      tick();
      send_valid_a = 1'b0;
      while (!req_a && n < 10) begin tick(); n++; end
      tests++;
      if (req_a !== 1'b1) begin fails++; $display("FAIL midrst_req_up: req=%b required 1", req_a); end
      #2 reset = 1'b1;
      #1;
      tests++;
      if (req_a !== 1'b0) begin fails++; $display("FAIL midrst_req: req=%b required 0", req_a); end
      tests++;
      if (tx_data_a !== 4'h0 || busy_a !== 1'b0) begin
         fails++;
         $display("FAIL midrst_clear: tx=%h busy=%b required 0 0", tx_data_a, busy_a);
      end
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      pico_en_a = 1'b0;
      repeat (30) begin
         tick();
         if (req_a) rises++;
         if (busy_a) busy_seen++;
      end
      tests++;
      if (rises != 0 || busy_seen != 0) begin
         fails++;
         $display("FAIL midrst_spurious: req-high %0d busy %0d clocks required 0 0", rises, busy_seen);
      end
   endtask

   task automatic test_refresh();
      int   done_at [$];
      int   rises, bad_word, tmo, drops;
      logic req_prev;
      rises = 0; bad_word = 0; tmo = 0; drops = 0; req_prev = 1'b0;
      do_reset();
      send_data_r = 4'hC;
      send_valid_r = 1'b1;
      tick();
      send_valid_r = 1'b0;
      for (int cyc = 1; cyc <= 1000; cyc++) begin
         tick();
         if (req_r && !req_prev) begin
            rises++;
            if (tx_data_r !== 4'hC) bad_word++;
         end
         req_prev = req_r;
         if (done_r) done_at.push_back(cyc);
         if (tmo_r) tmo++;
         if (drop_r) drops++;
         if (done_at.size() == 3) break;
      end
      tests++;
      if (done_at.size() != 3) begin fails++; $display("FAIL refresh_dones: got %0d required 3", done_at.size()); end
      tests++;
      if (done_at.size() < 1 || done_at[0] != 15) begin fails++; $display("FAIL refresh_first_done: first done clock wrong or missing, required 15"); end
      tests++;
      if (done_at.size() < 2 || done_at[1] - done_at[0] != 215) begin fails++; $display("FAIL refresh_period1: interval wrong or missing, required 215"); end
      tests++;
      if (done_at.size() < 3 || done_at[2] - done_at[1] != 215) begin fails++; $display("FAIL refresh_period2: interval wrong or missing, required 215"); end
      tests++;
      if (rises != 3 || bad_word != 0) begin
         fails++;
         $display("FAIL refresh_words: rises %0d bad words %0d required 3 0", rises, bad_word);
      end
      tests++;
      if (tmo != 0 || drops != 0) begin
         fails++;
         $display("FAIL refresh_clean: timeouts %0d drops %0d required 0 0", tmo, drops);
      end
      tests++;
      if (busy_r !== 1'b0) begin fails++; $display("FAIL refresh_idle: busy=%b required 0", busy_r); end
   endtask

   initial begin
      test_reset();
      test_single_send();
      test_back_to_back();
      test_timeout();
      test_stale_ack();
      test_reset_mid_transfer();
      test_refresh();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/status_tx_handshake.md
Name: status_tx_handshake

Overview:
Transmit side of the FPGA-Pico 4-phase REQ/ACK link. It carries filter-core status words from the FPGA to the Pico: pump activity, level flags and fault codes. The FPGA drives tx_data and req; the Pico answers on ack. The block sits in the top level beside the command receiver, fed by the filter FSM or status logic. It holds one pending word and can optionally resend the last word as a heartbeat.

Parameters:
DATA_WIDTH, 4, width of tx_data and send_data
SYNC_STAGES, 2, flops in the ack synchronizer (minimum 2)
SETUP_CYCLES, 2, clocks tx_data is stable before req rises (minimum 1)
TIMEOUT_CYCLES, 50_000_000, clocks allowed per ack edge before abort (1 s at 50 MHz)
REFRESH_CYCLES, 0, idle clocks before the last word is resent automatically; 0 disables

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
send_data  in  DATA_WIDTH  word to transmit
send_valid  in  1  request to send send_data; sampled every clock
ack  in  1  asynchronous acknowledge from Pico
req  out  1  request to Pico
tx_data  out  DATA_WIDTH  data to Pico; stable whenever req=1
busy  out  1  transfer in progress (state != IDLE) or pending word held
done_pulse  out  1  one clock at handshake completion
timeout_pulse  out  1  one clock when a transfer is aborted
drop_pulse  out  1  one clock when the pending word is overwritten

Behaviour:
- Reset (async): all outputs 0; state IDLE; pending empty; counters 0; synchronizer flops 0; last_word 0. Reset mid-transfer drops req in the same instant.
- ack passes through SYNC_STAGES flops to give ack_s. All decisions use ack_s only.
- States: IDLE, SETUP, WAIT_ACK_HI, WAIT_ACK_LO.
- Accept/launch:
  - In IDLE with send_valid=1 at edge N, or pending valid, and ack_s=0: tx_data and last_word load at edge N; state becomes SETUP.
  - Source priority: pending first, then send_data. If pending launches while send_valid=1, send_data becomes the new pending word.
- SETUP:
  - Count SETUP_CYCLES clocks, then req<=1 and enter WAIT_ACK_HI.
  - req first rises SETUP_CYCLES+1 edges after the accept edge.
- WAIT_ACK_HI:
  - On ack_s=1: req<=0, enter WAIT_ACK_LO.
  - If TIMEOUT_CYCLES clocks elapse without ack_s: req<=0, timeout_pulse, enter WAIT_ACK_LO. The word is not retried.
- WAIT_ACK_LO:
  - On ack_s=0: done_pulse (suppressed if this transfer timed out), enter IDLE.
  - If TIMEOUT_CYCLES elapse with ack_s still 1: timeout_pulse, enter IDLE.
- tx_data holds its value from launch until the next launch; it never changes while req=1.
- Pending register, 1 deep:
  - send_valid=1 in any state other than IDLE-and-launching stores send_data into pending.
  - If pending is already valid: overwrite (latest wins) and pulse drop_pulse.
  - send_valid held high across several clocks re-stores each clock. Producers pulse send_valid.
- IDLE with ack_s=1 (stale ack): no launch. Requests accumulate in pending; launch waits for ack_s=0.
- Refresh: when REFRESH_CYCLES>0, an idle counter runs in IDLE with nothing to send. At REFRESH_CYCLES it launches last_word as a normal transfer. Any launch clears the counter.
- Same-edge events: completion to IDLE plus send_valid → the word goes to pending and launches on the next clock. Timeout plus ack_s rising on the same edge → the timeout wins.
- Counters are sized with $clog2 of their maximum and saturate; no wrap-around.

Decomposition:
- filter_core_pkg: tx_state_t enum (IDLE, SETUP, WAIT_ACK_HI, WAIT_ACK_LO) and default timing constants (CLK_FREQ 50_000_000, DEFAULT_TX_TIMEOUT). The receiver reuses these.
- Sub-module sync_ff (parameter STAGES) for ack; also reusable for req on the receive side.

Test Plan:
- Single send: reset, then send_valid pulse with send_data=4'hA. Pico model raises ack 5 clocks after req and drops it 3 clocks after req falls. Expect tx_data=A at edge+1, req high at edge+3, req low SYNC_STAGES clocks after ack, one done_pulse, busy=0 after.
- Back-to-back: pulses with 4'h3, 4'h5, 4'h9 on consecutive clocks during transfer 1. Expect transmitted sequence 3,9; one drop_pulse; tx_data never changes while req=1.
- Timeout: TIMEOUT_CYCLES=100, send 4'h7, ack held 0. Expect req falls exactly 100 clocks after rising, one timeout_pulse, no done_pulse, return to IDLE.
- Stale ack: ack held 1 from reset, send 4'h2. Expect req stays 0 until ack falls; transfer then completes normally.
- Refresh: REFRESH_CYCLES=200, send 4'hC, then idle. Expect a retransmission of C every handshake-plus-200 clocks, each ending in done_pulse.
- Async reset asserted while req=1 mid-transfer: req, tx_data and busy go to 0 immediately. After release, no spurious transfer starts.
